// File: rtl/fp_op_scheduler.sv
// fp_op_scheduler: shares one float ALU between two clients with
// round-robin grant, operand latching, ALU handshake and a watchdog.
module fp_op_scheduler #(
  parameter int P       = 23,
  parameter int E       = 8,
  parameter int N       = P + E + 1,
  parameter int TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [1:0]     req_valid,
  output logic [1:0]     req_ready,
  input  logic [2*N-1:0] req_op_a,
  input  logic [2*N-1:0] req_op_b,
  input  logic [5:0]     req_op_code,
  input  logic [1:0]     req_mode_fp,
  input  logic [1:0]     req_round_mode,
  output logic [1:0]     rsp_valid,
  input  logic [1:0]     rsp_ready,
  output logic [N-1:0]   rsp_result,
  output logic [4:0]     rsp_flags,
  output logic           rsp_timeout,
  output logic [N-1:0]   alu_op_a,
  output logic [N-1:0]   alu_op_b,
  output logic [2:0]     alu_op_code,
  output logic           alu_mode_fp,
  output logic           alu_round_mode,
  output logic           alu_start,
  output logic           alu_ready_in,
  input  logic           alu_valid_out,
  input  logic           alu_ready_out,
  input  logic [N-1:0]   alu_result,
  input  logic [4:0]     alu_flags
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  localparam logic [7:0] WD_LAST  = 8'(TIMEOUT - 1);
  localparam logic [4:0] FLAG_INV = 5'b10000;

  state_t         state;
  logic           rr_ptr;
  logic           grant_id;
  logic [7:0]     wdog;
  logic [N-1:0]   op_a_q;
  logic [N-1:0]   op_b_q;
  logic [2:0]     op_code_q;
  logic           mode_fp_q;
  logic           round_mode_q;
  logic [N-1:0]   res_q;
  logic [4:0]     flags_q;
  logic           timeout_q;

  logic           grant;
  logic           any_req;
  logic           accept;
  logic           op_ok;
  logic           rsp_ack;
  logic [N-1:0]   sel_a;
  logic [N-1:0]   sel_b;
  logic [2:0]     sel_op;
  logic           sel_mode;
  logic           sel_rnd;

  assign any_req = |req_valid;
  assign accept  = |(req_valid & req_ready);
  assign rsp_ack = rsp_ready[grant_id];

  assign alu_op_a       = op_a_q;
  assign alu_op_b       = op_b_q;
  assign alu_op_code    = op_code_q;
  assign alu_mode_fp    = mode_fp_q;
  assign alu_round_mode = round_mode_q;
  assign rsp_result     = res_q;
  assign rsp_flags      = flags_q;
  assign rsp_timeout    = timeout_q;

  // Preferred client wins if valid, otherwise the other one
  always_comb begin
    grant = rr_ptr;
    if (!req_valid[rr_ptr]) grant = ~rr_ptr;
  end

  // Select the granted client's request fields
  always_comb begin
    sel_a    = grant ? req_op_a[2*N-1:N] : req_op_a[N-1:0];
    sel_b    = grant ? req_op_b[2*N-1:N] : req_op_b[N-1:0];
    sel_op   = grant ? req_op_code[5:3] : req_op_code[2:0];
    sel_mode = req_mode_fp[grant];
    sel_rnd  = req_round_mode[grant];
  end

  // Only add, sub, mul and div are sent to the ALU
  always_comb begin
    op_ok = 1'b0;
    unique case (sel_op)
      3'b000, 3'b001,
      3'b010, 3'b100: op_ok = 1'b1;
      default:        op_ok = 1'b0;
    endcase
  end

  // Handshake outputs from state, all forced low in reset
  always_comb begin
    req_ready    = '0;
    rsp_valid    = '0;
    alu_start    = 1'b0;
    alu_ready_in = 1'b0;
    if (rst_n) begin
      unique case (1'b1)
        (state == S_IDLE):  req_ready[grant] = any_req;
        (state == S_ISSUE): alu_start = alu_ready_out;
        (state == S_WAIT):  alu_ready_in = 1'b1;
        (state == S_RESP):  rsp_valid[grant_id] = 1'b1;
        default: ;
      endcase
    end
  end

  // Operation sequencer with latched request and response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      rr_ptr       <= 1'b0;
      grant_id     <= 1'b0;
      wdog         <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_code_q    <= '0;
      mode_fp_q    <= 1'b0;
      round_mode_q <= 1'b0;
      res_q        <= '0;
      flags_q      <= '0;
      timeout_q    <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            op_a_q       <= sel_a;
            op_b_q       <= sel_b;
            op_code_q    <= sel_op;
            mode_fp_q    <= sel_mode;
            round_mode_q <= sel_rnd;
            grant_id     <= grant;
            if (op_ok) begin
              state <= S_ISSUE;
            end else begin
              res_q     <= '0;
              flags_q   <= FLAG_INV;
              timeout_q <= 1'b0;
              state     <= S_RESP;
            end
          end
        end
        S_ISSUE: begin
          if (alu_ready_out) begin
            wdog  <= '0;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (alu_valid_out) begin
            res_q     <= alu_result;
            flags_q   <= alu_flags;
            timeout_q <= 1'b0;
            state     <= S_RESP;
          end else if (wdog == WD_LAST) begin
            res_q     <= '0;
            flags_q   <= FLAG_INV;
            timeout_q <= 1'b1;
            state     <= S_RESP;
          end else begin
            wdog <= wdog + 8'd1;
          end
        end
        S_RESP: begin
          if (rsp_ack) begin
            rr_ptr <= ~grant_id;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_op_scheduler.sv
// tb_fp_op_scheduler: random and directed operations against a
// timeline model of grant, issue, wait and response phases.
module tb_fp_op_scheduler;

  localparam int N  = 32;
  localparam int TO = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [1:0]     req_valid;
  logic [1:0]     req_ready;
  logic [2*N-1:0] req_op_a;
  logic [2*N-1:0] req_op_b;
  logic [5:0]     req_op_code;
  logic [1:0]     req_mode_fp;
  logic [1:0]     req_round_mode;
  logic [1:0]     rsp_valid;
  logic [1:0]     rsp_ready;
  logic [N-1:0]   rsp_result;
  logic [4:0]     rsp_flags;
  logic           rsp_timeout;
  logic [N-1:0]   alu_op_a;
  logic [N-1:0]   alu_op_b;
  logic [2:0]     alu_op_code;
  logic           alu_mode_fp;
  logic           alu_round_mode;
  logic           alu_start;
  logic           alu_ready_in;
  logic           alu_valid_out;
  logic           alu_ready_out;
  logic [N-1:0]   alu_result;
  logic [4:0]     alu_flags;

  fp_op_scheduler #(
    .P(23), .E(8), .N(N), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op_a(req_op_a), .req_op_b(req_op_b),
    .req_op_code(req_op_code),
    .req_mode_fp(req_mode_fp),
    .req_round_mode(req_round_mode),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags),
    .rsp_timeout(rsp_timeout),
    .alu_op_a(alu_op_a), .alu_op_b(alu_op_b),
    .alu_op_code(alu_op_code),
    .alu_mode_fp(alu_mode_fp),
    .alu_round_mode(alu_round_mode),
    .alu_start(alu_start), .alu_ready_in(alu_ready_in),
    .alu_valid_out(alu_valid_out),
    .alu_ready_out(alu_ready_out),
    .alu_result(alu_result), .alu_flags(alu_flags)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // model expectations
  logic [1:0]  e_req_ready, e_rsp_valid;
  logic        e_alu_start, e_alu_ready_in;
  logic [31:0] e_alu_a, e_alu_b, e_result;
  logic [2:0]  e_alu_op;
  logic        e_mf, e_rm, e_to;
  logic [4:0]  e_flags;
  int          pref;

  // client operands
  logic [31:0] oa [2];
  logic [31:0] ob [2];
  logic [2:0]  oc [2];
  logic        omf [2];
  logic        orm [2];

  // observations of the DUT
  int          mon_start = -1;
  int          n_start   = 0;
  int          mon_rsp   = -1;
  int          n_rsp     = 0;
  int          mon_id    = -1;
  logic [31:0] mon_res;
  logic [4:0]  mon_fl;
  logic        mon_to;
  logic        prev_rv   = 1'b0;

  task automatic cmp(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d: got %0h want %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic check_cycle();
    cmp("req_ready", 32'(req_ready), 32'(e_req_ready));
    cmp("rsp_valid", 32'(rsp_valid), 32'(e_rsp_valid));
    cmp("alu_start", 32'(alu_start), 32'(e_alu_start));
    cmp("alu_ready_in", 32'(alu_ready_in), 32'(e_alu_ready_in));
    cmp("rsp_result", rsp_result, e_result);
    cmp("rsp_flags", 32'(rsp_flags), 32'(e_flags));
    cmp("rsp_timeout", 32'(rsp_timeout), 32'(e_to));
    cmp("alu_op_a", alu_op_a, e_alu_a);
    cmp("alu_op_b", alu_op_b, e_alu_b);
    cmp("alu_op_code", 32'(alu_op_code), 32'(e_alu_op));
    cmp("alu_mode_fp", 32'(alu_mode_fp), 32'(e_mf));
    cmp("alu_round", 32'(alu_round_mode), 32'(e_rm));
    if (alu_start) begin
      mon_start = cyc;
      n_start++;
    end
    if ((|rsp_valid) && !prev_rv) begin
      mon_rsp = cyc;
      n_rsp++;
      mon_res = rsp_result;
      mon_fl  = rsp_flags;
      mon_to  = rsp_timeout;
      mon_id  = rsp_valid[1] ? 1 : 0;
    end
    prev_rv = |rsp_valid;
  endtask

  task automatic step();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic hs(input logic [1:0] rr, input logic [1:0] rv,
                    input logic st, input logic ri);
    e_req_ready    = rr;
    e_rsp_valid    = rv;
    e_alu_start    = st;
    e_alu_ready_in = ri;
  endtask

  task automatic clear_exp();
    e_alu_a  = '0;
    e_alu_b  = '0;
    e_alu_op = '0;
    e_mf     = 1'b0;
    e_rm     = 1'b0;
    e_result = '0;
    e_flags  = '0;
    e_to     = 1'b0;
  endtask

  task automatic drive_req();
    req_op_a       = {oa[1], oa[0]};
    req_op_b       = {ob[1], ob[0]};
    req_op_code    = {oc[1], oc[0]};
    req_mode_fp    = {omf[1], omf[0]};
    req_round_mode = {orm[1], orm[0]};
  endtask

  task automatic rand_ops();
    for (int i = 0; i < 2; i++) begin
      oa[i]  = $urandom;
      ob[i]  = $urandom;
      omf[i] = 1'($urandom);
      orm[i] = 1'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        oc[i] = 3'($urandom_range(0, 7));
      end else begin
        case ($urandom_range(0, 3))
          0:       oc[i] = 3'd0;
          1:       oc[i] = 3'd1;
          2:       oc[i] = 3'd2;
          default: oc[i] = 3'd4;
        endcase
      end
    end
  endtask

  task automatic noise();
    alu_valid_out = 1'($urandom);
    alu_ready_out = 1'($urandom);
    alu_result    = $urandom;
    alu_flags     = 5'($urandom);
  endtask

  function automatic bit supported(input logic [2:0] c);
    return (c == 3'd0) || (c == 3'd1) || (c == 3'd2) || (c == 3'd4);
  endfunction

  // One operation: accept, optional ISSUE stall of dr cycles, ALU
  // latency lat (beyond TO means hung), response held ds cycles.
  task automatic run_op(input logic [1:0] vpat, input int dr,
                        input int lat, input int ds,
                        input logic [31:0] res, input logic [4:0] fl,
                        output int gid, output int t_acc);
    int nw;
    int oth;
    drive_req();
    noise();
    rsp_ready = '0;
    req_valid = vpat;
    if (pref == 1) gid = vpat[1] ? 1 : 0;
    else           gid = vpat[0] ? 0 : 1;
    hs(2'(1 << gid), 2'b00, 1'b0, 1'b0);
    t_acc = cyc;
    step();
    e_alu_a  = oa[gid];
    e_alu_b  = ob[gid];
    e_alu_op = oc[gid];
    e_mf     = omf[gid];
    e_rm     = orm[gid];
    if (supported(oc[gid])) begin
      for (int k = 0; k < dr; k++) begin
        noise();
        alu_ready_out = 1'b0;
        req_valid = 2'($urandom);
        hs(2'b00, 2'b00, 1'b0, 1'b0);
        step();
      end
      noise();
      alu_ready_out = 1'b1;
      req_valid = 2'($urandom);
      hs(2'b00, 2'b00, 1'b1, 1'b0);
      step();
      nw = (lat > TO) ? TO : lat;
      for (int k = 0; k < nw; k++) begin
        alu_ready_out = 1'($urandom);
        req_valid     = 2'($urandom);
        alu_valid_out = (k == lat - 1);
        alu_result    = alu_valid_out ? res : $urandom;
        alu_flags     = alu_valid_out ? fl : 5'($urandom);
        hs(2'b00, 2'b00, 1'b0, 1'b1);
        step();
      end
      if (lat <= TO) begin
        e_result = res;
        e_flags  = fl;
        e_to     = 1'b0;
      end else begin
        e_result = '0;
        e_flags  = 5'b10000;
        e_to     = 1'b1;
      end
    end else begin
      e_result = '0;
      e_flags  = 5'b10000;
      e_to     = 1'b0;
    end
    oth = 1 - gid;
    for (int k = 0; k <= ds; k++) begin
      noise();
      req_valid = 2'($urandom);
      rsp_ready = 2'(($urandom % 2) << oth);
      if (k == ds) rsp_ready[gid] = 1'b1;
      hs(2'b00, 2'(1 << gid), 1'b0, 1'b0);
      step();
    end
    rsp_ready = '0;
    req_valid = '0;
    pref = 1 - gid;
  endtask

  task automatic idle_cycle();
    noise();
    req_valid = '0;
    rsp_ready = 2'($urandom);
    hs(2'b00, 2'b00, 1'b0, 1'b0);
    step();
  endtask

  initial begin
    int gid;
    int ta;
    int s0;
    int r0;
    rst_n = 1'b0;
    pref  = 0;
    rand_ops();
    drive_req();
    noise();
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    clear_exp();
    hs(2'b00, 2'b00, 1'b0, 1'b0);
    repeat (3) step();
    rst_n = 1'b1;
    idle_cycle();

    // add 1.0 + 2.0 with a 3-cycle ALU
    rand_ops();
    oa[0] = 32'h3F800000;
    ob[0] = 32'h40000000;
    oc[0] = 3'b000;
    s0 = n_start;
    run_op(2'b01, 0, 3, 0, 32'h40400000, 5'h00, gid, ta);
    cmp("t1_start_lat", 32'(mon_start - ta), 32'd1);
    cmp("t1_start_cnt", 32'(n_start - s0), 32'd1);
    cmp("t1_rsp_lat", 32'(mon_rsp - ta), 32'd5);
    cmp("t1_result", mon_res, 32'h40400000);
    cmp("t1_timeout", 32'(mon_to), 32'd0);
    cmp("t1_id", 32'(mon_id), 32'd0);

    // unsupported op code from client 1
    rand_ops();
    oc[1] = 3'b011;
    s0 = n_start;
    run_op(2'b10, 0, 1, 0, 32'h0, 5'h0, gid, ta);
    cmp("uns_start_cnt", 32'(n_start - s0), 32'd0);
    cmp("uns_rsp_lat", 32'(mon_rsp - ta), 32'd1);
    cmp("uns_result", mon_res, 32'd0);
    cmp("uns_flags", 32'(mon_fl), 32'h10);
    cmp("uns_id", 32'(mon_id), 32'd1);

    // hung ALU hits the watchdog
    rand_ops();
    oc[0] = 3'b010;
    run_op(2'b01, 0, TO + 5, 1, 32'h0, 5'h0, gid, ta);
    cmp("wd_rsp_lat", 32'(mon_rsp - mon_start), 32'd9);
    cmp("wd_timeout", 32'(mon_to), 32'd1);
    cmp("wd_flags", 32'(mon_fl), 32'h10);

    // ALU busy for 5 cycles, response held 4 cycles
    rand_ops();
    oc[1] = 3'b100;
    s0 = n_start;
    run_op(2'b11, 5, 2, 4, 32'hCAFE0001, 5'h03, gid, ta);
    cmp("st_start_lat", 32'(mon_start - ta), 32'd6);
    cmp("st_start_cnt", 32'(n_start - s0), 32'd1);
    cmp("st_id", 32'(mon_id), 32'd1);
    cmp("st_result", mon_res, 32'hCAFE0001);

    // reset in the middle of WAIT
    rand_ops();
    oc[0] = 3'b001;
    drive_req();
    noise();
    req_valid = 2'b01;
    hs(2'b01, 2'b00, 1'b0, 1'b0);
    step();
    e_alu_a  = oa[0];
    e_alu_b  = ob[0];
    e_alu_op = oc[0];
    e_mf     = omf[0];
    e_rm     = orm[0];
    noise();
    alu_ready_out = 1'b1;
    req_valid = '0;
    hs(2'b00, 2'b00, 1'b1, 1'b0);
    step();
    repeat (2) begin
      alu_valid_out = 1'b0;
      hs(2'b00, 2'b00, 1'b0, 1'b1);
      step();
    end
    rst_n = 1'b0;
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    alu_valid_out = 1'b1;
    clear_exp();
    hs(2'b00, 2'b00, 1'b0, 1'b0);
    repeat (2) step();
    rst_n = 1'b1;
    req_valid = '0;
    rsp_ready = '0;
    pref = 0;
    r0 = n_rsp;
    repeat (3) begin
      alu_valid_out = 1'b1;
      alu_result = $urandom;
      hs(2'b00, 2'b00, 1'b0, 1'b0);
      step();
    end
    cmp("rst_no_rsp", 32'(n_rsp - r0), 32'd0);

    // continuous contention alternates starting at client 0
    for (int i = 0; i < 4; i++) begin
      rand_ops();
      oc[0] = 3'b000;
      oc[1] = 3'b010;
      run_op(2'b11, 0, 2, 0, $urandom, 5'($urandom), gid, ta);
      cmp("alt_id", 32'(mon_id), 32'(i % 2));
    end

    // random traffic
    repeat (300) begin
      if ($urandom_range(0, 3) == 0) idle_cycle();
      rand_ops();
      run_op(2'($urandom_range(1, 3)), $urandom_range(0, 3),
             $urandom_range(1, TO + 2), $urandom_range(0, 3),
             $urandom, 5'($urandom), gid, ta);
    end
    idle_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
